// File: rtl/led_pattern_engine_if.sv
// Control and status bundle for led_pattern_engine: speed/mode/pause in, pattern/tick/mode out.
// Signal names follow the block's external pin names.
interface led_pattern_engine_if #(
    parameter int unsigned N_LED = 8
) ();
    logic [1:0]       Select;
    logic [2:0]       MODE;
    logic             pause;
    logic [N_LED-1:0] LED;
    logic             tick;
    logic [2:0]       mode_o;

    modport master (output Select, MODE, pause, input LED, tick, mode_o);
    modport slave  (input Select, MODE, pause, output LED, tick, mode_o);
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern generator: prescaled step tick drives one of eight selectable patterns.
// MODE is an asynchronous switch input; it is synchronised before any use.
module led_pattern_engine #(
    parameter int unsigned N_LED    = 8,
    parameter int unsigned BASE_DIV = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    led_pattern_engine_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BASE_DIV) + 4;
    localparam int unsigned IDX_W = $clog2(N_LED);
    localparam int unsigned K_W   = $clog2(N_LED + 1);
    localparam int unsigned FW    = N_LED + 1;

    function automatic logic [N_LED-1:0] alt_init();
        logic [N_LED-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N_LED); i += 2) v[i] = 1'b1;
        return v;
    endfunction

    localparam logic [N_LED-1:0] ALT_INIT = alt_init();

    logic [2:0]       r_mode_s1, r_mode_s2, r_mode;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [N_LED-1:0] r_led;
    logic             r_tick;
    logic [IDX_W-1:0] r_idx;
    logic             r_dir;
    logic [K_W-1:0]   r_k;

    logic [2:0]       w_mode_nxt;
    logic [1:0]       w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_nxt, w_term;
    logic [N_LED-1:0] w_led_nxt, w_init, w_fill;
    logic             w_tick_nxt, w_dir_nxt, w_dir_step;
    logic [IDX_W-1:0] w_idx_nxt, w_idx_step;
    logic [K_W-1:0]   w_k_nxt, w_k_step;

    assign w_term = (CNT_W'(BASE_DIV) << r_sel) - CNT_W'(1);

    // Starting pattern for the mode about to be loaded
    always_comb begin
        w_init = '0;
        case (r_mode_s2)
            3'd1:    w_init = N_LED'(1);
            3'd2:    w_init = {1'b1, {(N_LED-1){1'b0}}};
            3'd3:    w_init = N_LED'(1);
            3'd5:    w_init = '1;
            3'd6:    w_init = ALT_INIT;
            default: w_init = '0;
        endcase
    end

    // Ping-pong bounces at both ends so each endpoint is shown once per pass
    always_comb begin
        w_idx_step = r_idx;
        w_dir_step = r_dir;
        if (!r_dir) begin
            if (r_idx == IDX_W'(N_LED - 1)) begin
                w_dir_step = 1'b1;
                w_idx_step = IDX_W'(N_LED - 2);
            end else begin
                w_idx_step = r_idx + IDX_W'(1);
            end
        end else begin
            if (r_idx == '0) begin
                w_dir_step = 1'b0;
                w_idx_step = IDX_W'(1);
            end else begin
                w_idx_step = r_idx - IDX_W'(1);
            end
        end
    end

    assign w_k_step = (r_k == K_W'(N_LED)) ? '0 : r_k + K_W'(1);
    assign w_fill   = N_LED'((FW'(1) << w_k_step) - FW'(1));

    // Next state: mode load beats pause, pause beats Select restart and tick
    always_comb begin
        w_mode_nxt = r_mode;
        w_sel_nxt  = r_sel;
        w_cnt_nxt  = r_cnt;
        w_led_nxt  = r_led;
        w_tick_nxt = 1'b0;
        w_idx_nxt  = r_idx;
        w_dir_nxt  = r_dir;
        w_k_nxt    = r_k;
        if (r_mode_s2 != r_mode) begin
            w_mode_nxt = r_mode_s2;
            w_sel_nxt  = bus.Select;
            w_cnt_nxt  = '0;
            w_led_nxt  = w_init;
            w_idx_nxt  = '0;
            w_dir_nxt  = 1'b0;
            w_k_nxt    = '0;
        end else if (!bus.pause) begin
            w_sel_nxt = bus.Select;
            if (bus.Select != r_sel) begin
                w_cnt_nxt = '0;
            end else if (r_cnt == w_term) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                case (r_mode)
                    3'd1: w_led_nxt = {r_led[N_LED-2:0], r_led[N_LED-1]};
                    3'd2: w_led_nxt = {r_led[0], r_led[N_LED-1:1]};
                    3'd3: begin
                        w_idx_nxt = w_idx_step;
                        w_dir_nxt = w_dir_step;
                        w_led_nxt = N_LED'(1) << w_idx_step;
                    end
                    3'd4: begin
                        w_k_nxt   = w_k_step;
                        w_led_nxt = w_fill;
                    end
                    3'd5, 3'd6: w_led_nxt = ~r_led;
                    3'd7: w_led_nxt = r_led + N_LED'(1);
                    default: w_led_nxt = '0;
                endcase
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
            r_mode    <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_led     <= '0;
            r_tick    <= 1'b0;
            r_idx     <= '0;
            r_dir     <= 1'b0;
            r_k       <= '0;
        end else begin
            r_mode_s1 <= bus.MODE;
            r_mode_s2 <= r_mode_s1;
            r_mode    <= w_mode_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_led     <= w_led_nxt;
            r_tick    <= w_tick_nxt;
            r_idx     <= w_idx_nxt;
            r_dir     <= w_dir_nxt;
            r_k       <= w_k_nxt;
        end
    end

    assign bus.LED    = r_led;
    assign bus.tick   = r_tick;
    assign bus.mode_o = r_mode;
endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL provide parameter N_LED, default 8, number of LED outputs; legal range 2..32.
REQ-002 SHALL provide parameter BASE_DIV, default 1000000, clk cycles per pattern step at speed 0; legal range 2..2^24.
REQ-003 SHALL provide port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port Select  input  2  speed select; step period = BASE_DIV << Select clk cycles.
REQ-006 SHALL provide port MODE  input  3  pattern select, asynchronous switch input.
REQ-007 SHALL provide port pause  input  1  freezes pattern and prescaler while high, synchronous.
REQ-008 SHALL provide port LED  output  N_LED  registered pattern output.
REQ-009 SHALL provide port tick  output  1  one-clk pulse on every pattern step.
REQ-010 SHALL provide port mode_o  output  3  currently active mode.

Function
REQ-011 SHALL pass MODE through a 2-flop synchroniser before any use.
REQ-012 SHALL run the prescaler from 0 to (BASE_DIV << Select) - 1, pulse tick for one cycle at terminal count, then wrap to 0.
REQ-013 SHALL restart the prescaler at 0, with no tick, in the cycle after any change of Select.
REQ-014 SHALL hold the prescaler, pattern state and LED unchanged while pause = 1; tick stays 0.
REQ-015 SHALL, when synchronised MODE differs from mode_o, load the new mode, its initial pattern and prescaler = 0 on the next clk edge, regardless of pause or tick.
REQ-016 SHALL give mode change priority over a tick coinciding in the same cycle; the tick is dropped.
REQ-017 SHALL apply the following on each tick, LED[0] = index 0:
REQ-018 Mode 0 OFF: LED = 0, constant.
REQ-019 Mode 1 SHIFT-LEFT: initial LED = 1; rotate left by one; LED[N_LED-1] wraps to LED[0].
REQ-020 Mode 2 SHIFT-RIGHT: initial LED = 1 << (N_LED-1); rotate right by one; LED[0] wraps to the top.
REQ-021 Mode 3 PING-PONG: single dot; index idx, initial 0, direction up; sequence 0,1..N_LED-1,N_LED-2..0,1..; period 2*N_LED-2 ticks; endpoints shown once per pass.
REQ-022 Mode 4 FILL: count k, initial 0; LED = (1<<k)-1; k advances 0..N_LED then wraps to 0; period N_LED+1 ticks.
REQ-023 Mode 5 BLINK: initial all ones; invert every tick.
REQ-024 Mode 6 ALTERNATE: initial LED[i] = 1 for even i; invert every tick.
REQ-025 Mode 7 COUNT: initial 0; LED increments by 1 modulo 2^N_LED.
REQ-026 SHALL drive LED from registers only, with no combinational path from any input to LED.
REQ-027 SHALL make mode_o equal the mode register loaded per REQ-015.

Reset
REQ-028 SHALL, while reset = 0, force LED = 0, tick = 0, mode_o = 0, prescaler = 0, synchroniser flops = 0, ping-pong idx = 0 with direction up, and fill k = 0.
REQ-029 SHALL, on reset release, run in mode 0 until the synchronised MODE causes a load per REQ-015.
REQ-030 SHALL, when reset is asserted mid-pattern, clear all state immediately without waiting for clk; no partial step is completed.

Verification (BASE_DIV=2, N_LED=8)
REQ-031 Reset release with MODE=1, Select=0 -> mode_o=1 and LED=0x01 on the 3rd edge; then LED=0x02,0x04 every 2 clks; 0x80 wraps to 0x01.
REQ-032 MODE=3, Select=1 -> LED steps every 4 clks: 01,02..80,40..01,02; 14 ticks per period; 0x80 and 0x01 each seen once per pass.
REQ-033 MODE=4 -> LED sequence 00,01,03,07..FF,00; MODE=7 -> LED counts 00..FF then 00.
REQ-034 pause=1 for 10 clks mid-MODE=6 -> LED and tick frozen; on release the next toggle occurs exactly 2 clks later.
REQ-035 MODE changes 5->2 in the same cycle a tick is due -> no tick; LED=0x80 after synchroniser latency; the prescaler restarts; Select change gives the same restart.
REQ-036 reset=0 asserted between clk edges during MODE=1 -> LED=0, mode_o=0, tick=0 immediately, before the next clk edge.
